// File: rtl/spi_master_gen.sv
// Parametrised SPI master: DATA_W-bit words, CLK_DIV half-period, NUM_CS selects, modes 0-3.
// Define SPI_LSB_FIRST_EN to add the lsb_first port for LSB-first transfers.
module spi_master_gen #(
   parameter int DATA_W  = 8,
   parameter int CLK_DIV = 4,
   parameter int NUM_CS  = 1
) (
   input  logic                                      clk,
   input  logic                                      reset,
   input  logic                                      start,
   input  logic                                      cpol,
   input  logic                                      cpha,
   input  logic [((NUM_CS > 1) ? $clog2(NUM_CS) : 1)-1:0] cs_sel,
   input  logic [DATA_W-1:0]                         data_in,
`ifdef SPI_LSB_FIRST_EN
   input  logic                                      lsb_first,
`endif
   input  logic                                      MISO,
   output logic                                      MOSI,
   output logic                                      SCK,
   output logic [NUM_CS-1:0]                         CS,
   output logic [DATA_W-1:0]                         data_out,
   output logic                                      done,
   output logic                                      busy
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int EW = $clog2(2 * DATA_W + 1);
   localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
   localparam logic [EW-1:0] EDGE_LAST = EW'(2 * DATA_W);

   typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, DONE} state_t;

   state_t              state, state_d;
   logic [CW-1:0]       cnt, cnt_d;
   logic [EW-1:0]       edges, edges_d, edge_n;
   logic [DATA_W-1:0]   tx_sr, tx_d, rx_sr, rx_d, data_out_d;
   logic                cpol_q, cpha_q, lsb_q;
   logic                cpol_d, cpha_d, lsb_d;
   logic                sck_d, mosi_d, done_d, busy_d;
   logic [NUM_CS-1:0]   cs_d;
   logic                lsb_in, cnt_end, lead, smp, drv;

`ifdef SPI_LSB_FIRST_EN
   assign lsb_in = lsb_first;
`else
   assign lsb_in = 1'b0;
`endif

   function automatic logic first_bit(input logic [DATA_W-1:0] w,
                                      input logic lsb);
      return lsb ? w[0] : w[DATA_W-1];
   endfunction

   function automatic logic [DATA_W-1:0] shift_word(input logic [DATA_W-1:0] w,
                                                    input logic lsb);
      return lsb ? {1'b0, w[DATA_W-1:1]} : {w[DATA_W-2:0], 1'b0};
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         edges    <= '0;
         tx_sr    <= '0;
         rx_sr    <= '0;
         cpol_q   <= 1'b0;
         cpha_q   <= 1'b0;
         lsb_q    <= 1'b0;
         SCK      <= 1'b0;
         MOSI     <= 1'b0;
         CS       <= '1;
         data_out <= '0;
         done     <= 1'b0;
         busy     <= 1'b0;
      end else begin
         state    <= state_d;
         cnt      <= cnt_d;
         edges    <= edges_d;
         tx_sr    <= tx_d;
         rx_sr    <= rx_d;
         cpol_q   <= cpol_d;
         cpha_q   <= cpha_d;
         lsb_q    <= lsb_d;
         SCK      <= sck_d;
         MOSI     <= mosi_d;
         CS       <= cs_d;
         data_out <= data_out_d;
         done     <= done_d;
         busy     <= busy_d;
      end
   end

   always_comb begin
      state_d    = state;
      cnt_d      = cnt;
      edges_d    = edges;
      tx_d       = tx_sr;
      rx_d       = rx_sr;
      cpol_d     = cpol_q;
      cpha_d     = cpha_q;
      lsb_d      = lsb_q;
      sck_d      = SCK;
      mosi_d     = MOSI;
      cs_d       = CS;
      data_out_d = data_out;
      done_d     = 1'b0;
      busy_d     = busy;
      cnt_end    = (cnt == CNT_LAST);
      edge_n     = edges + 1'b1;
      lead       = edge_n[0];
      smp        = cpha_q ? !lead : lead;
      // CPHA=0 already put bit 0 out in SETUP, so it has no drive on the last edge
      drv        = cpha_q ? lead : (!lead && edge_n != EDGE_LAST);

      unique case (state)
         IDLE: begin
            sck_d   = cpol;
            mosi_d  = 1'b0;
            cnt_d   = '0;
            edges_d = '0;
            if (start && int'(cs_sel) < NUM_CS) begin
               state_d = SETUP;
               cpol_d  = cpol;
               cpha_d  = cpha;
               lsb_d   = lsb_in;
               cs_d    = ~(NUM_CS'(1) << cs_sel);
               busy_d  = 1'b1;
               rx_d    = '0;
               if (!cpha) begin
                  mosi_d = first_bit(data_in, lsb_in);
                  tx_d   = shift_word(data_in, lsb_in);
               end else begin
                  tx_d   = data_in;
               end
            end
         end
         SETUP: begin
            cnt_d = cnt + 1'b1;
            if (cnt_end) begin
               cnt_d   = '0;
               state_d = XFER;
            end
         end
         XFER: begin
            cnt_d = cnt + 1'b1;
            if (cnt_end) begin
               cnt_d   = '0;
               sck_d   = ~SCK;
               edges_d = edge_n;
               if (smp) begin
                  rx_d = lsb_q ? {MISO, rx_sr[DATA_W-1:1]}
                               : {rx_sr[DATA_W-2:0], MISO};
               end
               if (drv) begin
                  mosi_d = first_bit(tx_sr, lsb_q);
                  tx_d   = shift_word(tx_sr, lsb_q);
               end
               if (edge_n == EDGE_LAST) state_d = HOLD;
            end
         end
         HOLD: begin
            cnt_d = cnt + 1'b1;
            if (cnt_end) begin
               cnt_d      = '0;
               state_d    = DONE;
               cs_d       = '1;
               mosi_d     = 1'b0;
               done_d     = 1'b1;
               data_out_d = rx_sr;
            end
         end
         DONE: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            sck_d   = cpol_q;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_spi_master_gen.sv
// Directed bench for spi_master_gen (DATA_W=8, CLK_DIV=2, NUM_CS=3) with an SPI slave model.
// Build with SPI_LSB_FIRST_EN defined to also exercise LSB-first loopback.
module tb_spi_master_gen;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       cpol = 1'b0;
   logic       cpha = 1'b0;
   logic [1:0] cs_sel = 2'd0;
   logic [7:0] data_in = 8'h00;
   logic       MISO = 1'b0;
   logic       MOSI, SCK, done, busy;
   logic [2:0] CS;
   logic [7:0] data_out;
`ifdef SPI_LSB_FIRST_EN
   logic       lsb_first = 1'b0;
`endif

   int checks = 0;
   int errors = 0;

   // slave model state
   logic [7:0] slave_word = 8'h3C;
   logic [7:0] cap = 8'h00;
   bit         m_cpha = 1'b0;
   bit         loopback = 1'b0;
   bit         cs_low = 1'b0;
   logic       prev_sck = 1'b0;
   int         nedge = 0;

   always #5 clk = ~clk;

   spi_master_gen #(.DATA_W(8), .CLK_DIV(2), .NUM_CS(3)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .cpol      (cpol),
      .cpha      (cpha),
      .cs_sel    (cs_sel),
      .data_in   (data_in),
`ifdef SPI_LSB_FIRST_EN
      .lsb_first (lsb_first),
`endif
      .MISO      (MISO),
      .MOSI      (MOSI),
      .SCK       (SCK),
      .CS        (CS),
      .data_out  (data_out),
      .done      (done),
      .busy      (busy)
   );

   // Slave: shifts slave_word out MSB first and captures MOSI on sampling edges
   always @(negedge clk) begin
      if (&CS) begin
         cs_low = 1'b0;
      end else begin
         if (!cs_low) begin
            cs_low = 1'b1;
            nedge  = 0;
            cap    = 8'h00;
            if (!m_cpha) MISO = slave_word[7];
         end
         if (SCK !== prev_sck) begin
            nedge++;
            if (!m_cpha) begin
               if (nedge % 2 == 1) cap = {cap[6:0], MOSI};
               else if (nedge < 16) MISO = slave_word[7 - nedge / 2];
            end else begin
               if (nedge % 2 == 1) MISO = slave_word[7 - (nedge - 1) / 2];
               else cap = {cap[6:0], MOSI};
            end
         end
      end
      if (loopback) MISO = MOSI;
      prev_sck = SCK;
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic xfer(input logic [7:0] d, input logic pol, input logic pha,
                       input logic [1:0] sel, output int n, output bit ok,
                       output logic m1, output logic [2:0] cs1,
                       output logic b1);
      @(negedge clk);
      cpol = pol;
      cpha = pha;
      m_cpha = pha;
      repeat (3) @(negedge clk);
      chk("idle_sck", 32'(SCK), 32'(pol));
      data_in = d;
      cs_sel = sel;
      start = 1'b1;
      n = 0;
      ok = 1'b0;
      m1 = 1'b0;
      cs1 = 3'b000;
      b1 = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk);
         #1;
         n++;
         if (n == 1) begin
            start = 1'b0;
            m1 = MOSI;
            cs1 = CS;
            b1 = busy;
         end
         if (done) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   int         n, n2;
   bit         ok, saw;
   logic       m1, b1;
   logic [2:0] cs1;
   logic [1:0] mm;

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_cs", 32'(CS), 32'h7);
      chk("rst_sck", 32'(SCK), 32'h0);
      chk("rst_mosi", 32'(MOSI), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_done", 32'(done), 32'h0);
      chk("rst_dout", 32'(data_out), 32'h0);
      @(negedge clk);
      reset = 1'b0;

      // mode 0, 0xA5 out, 0x3C back
      xfer(8'hA5, 1'b0, 1'b0, 2'd0, n, ok, m1, cs1, b1);
      chk("m0_done_seen", 32'(ok), 32'h1);
      chk("m0_latency", 32'(n), 32'd37);
      chk("m0_rx", 32'(data_out), 32'h3C);
      chk("m0_mosi_bits", 32'(cap), 32'hA5);
      chk("m0_first_mosi", 32'(m1), 32'h1);
      chk("m0_cs_low", 32'(cs1), 32'h6);
      chk("m0_busy_start", 32'(b1), 32'h1);
      chk("m0_busy_done", 32'(busy), 32'h1);
      chk("m0_cs_done", 32'(CS), 32'h7);
      @(posedge clk);
      #1;
      chk("m0_done_pulse", 32'(done), 32'h0);
      chk("m0_busy_end", 32'(busy), 32'h0);
      chk("m0_dout_hold", 32'(data_out), 32'h3C);

      // modes 1..3
      for (int m = 1; m < 4; m++) begin
         mm = 2'(m);
         xfer(8'hA5, mm[1], mm[0], 2'd0, n, ok, m1, cs1, b1);
         chk("mode_done_seen", 32'(ok), 32'h1);
         chk("mode_latency", 32'(n), 32'd37);
         chk("mode_rx", 32'(data_out), 32'h3C);
         chk("mode_mosi_bits", 32'(cap), 32'hA5);
         repeat (2) @(posedge clk);
         #1;
         chk("mode_sck_after", 32'(SCK), 32'(mm[1]));
      end

      // chip select 2
      xfer(8'h96, 1'b0, 1'b0, 2'd2, n, ok, m1, cs1, b1);
      chk("cs2_low", 32'(cs1), 32'h3);
      chk("cs2_rx", 32'(data_out), 32'h3C);
      chk("cs2_mosi_bits", 32'(cap), 32'h96);

      // cs_sel 3 is out of range for three selects
      @(negedge clk);
      cs_sel = 2'd3;
      data_in = 8'hFF;
      start = 1'b1;
      saw = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(posedge clk);
         #1;
         if (CS !== 3'b111 || done || busy) saw = 1'b1;
      end
      start = 1'b0;
      chk("bad_cs_ignored", 32'(saw), 32'h0);
      chk("bad_cs_dout", 32'(data_out), 32'h3C);

      // back-to-back with start held and data_in changed mid-transfer
      @(negedge clk);
      cpol = 1'b0;
      cpha = 1'b0;
      m_cpha = 1'b0;
      cs_sel = 2'd1;
      data_in = 8'h5A;
      start = 1'b1;
      n = 0;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk);
         #1;
         n++;
         if (n == 10) data_in = 8'hC3;
         if (done) begin
            ok = 1'b1;
            break;
         end
      end
      chk("b2b_first_done", 32'(ok), 32'h1);
      chk("b2b_first_lat", 32'(n), 32'd37);
      chk("b2b_first_mosi", 32'(cap), 32'h5A);
      @(posedge clk);
      #1;
      chk("b2b_idle_gap", 32'(busy), 32'h0);
      @(posedge clk);
      #1;
      chk("b2b_restart", 32'(busy), 32'h1);
      chk("b2b_cs1", 32'(CS), 32'h5);
      start = 1'b0;
      n2 = 0;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk);
         #1;
         n2++;
         if (done) begin
            ok = 1'b1;
            break;
         end
      end
      chk("b2b_second_done", 32'(ok), 32'h1);
      chk("b2b_second_lat", 32'(n2), 32'd36);
      chk("b2b_second_mosi", 32'(cap), 32'hC3);
      chk("b2b_second_rx", 32'(data_out), 32'h3C);

      // reset at SCK edge 7, mode 2 so SCK and MOSI are high beforehand
      @(negedge clk);
      cpol = 1'b1;
      cpha = 1'b0;
      m_cpha = 1'b0;
      repeat (3) @(negedge clk);
      cs_sel = 2'd0;
      data_in = 8'hFF;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (15) @(posedge clk);
      @(negedge clk);
      chk("pre_rst_busy", 32'(busy), 32'h1);
      chk("pre_rst_edges", 32'(nedge), 32'd6);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("mid_rst_cs", 32'(CS), 32'h7);
      chk("mid_rst_sck", 32'(SCK), 32'h0);
      chk("mid_rst_mosi", 32'(MOSI), 32'h0);
      chk("mid_rst_busy", 32'(busy), 32'h0);
      chk("mid_rst_dout", 32'(data_out), 32'h0);
      chk("mid_rst_done", 32'(done), 32'h0);
      @(negedge clk);
      reset = 1'b0;
      saw = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(posedge clk);
         #1;
         if (done || busy) saw = 1'b1;
      end
      chk("post_rst_quiet", 32'(saw), 32'h0);

`ifdef SPI_LSB_FIRST_EN
      loopback = 1'b1;
      lsb_first = 1'b1;
      xfer(8'h01, 1'b0, 1'b0, 2'd0, n, ok, m1, cs1, b1);
      chk("lsb_done_seen", 32'(ok), 32'h1);
      chk("lsb_first_mosi", 32'(m1), 32'h1);
      chk("lsb_loop_rx", 32'(data_out), 32'h01);
      xfer(8'h80, 1'b0, 1'b0, 2'd0, n, ok, m1, cs1, b1);
      chk("lsb_first_mosi2", 32'(m1), 32'h0);
      chk("lsb_loop_rx2", 32'(data_out), 32'h80);
      lsb_first = 1'b0;
      loopback = 1'b0;
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
